// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one 3-to-8 decoded resource among
// 8 requesters. Grants are held until done, request drop or the hold limit,
// followed by a single idle bubble and a rotated scan start.
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       valid,
  output logic [7:0] grant,
  output logic       timeout
);

  localparam int unsigned HW = 8;
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [2:0]      sel_d;
  logic            valid_d;
  logic [7:0]      grant_d;
  logic            timeout_d;
  logic [2:0]      win;
  logic            at_limit;
  logic            release_c;

  // First requester at or after ptr, wrapping modulo 8 (lowest offset wins).
  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) win = ptr_q + 3'(i);
    end
  end

  // Release conditions for the current owner.
  always_comb begin
    at_limit  = (hold_q == HOLD_LIM);
    release_c = done | ~req[sel] | at_limit;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = sel;
    valid_d   = valid;
    grant_d   = grant;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        grant_d = 8'h00;
        if (|req) begin
          state_d = GRANT;
          sel_d   = win;
          valid_d = 1'b1;
          grant_d = 8'h01 << win;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (release_c) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          grant_d   = 8'h00;
          ptr_d     = sel + 3'd1;
          hold_d    = '0;
          timeout_d = ~done & req[sel] & at_limit;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = 8'h00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
      sel     <= 3'd0;
      valid   <= 1'b0;
      grant   <= 8'h00;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      sel     <= sel_d;
      valid   <= valid_d;
      grant   <= grant_d;
      timeout <= timeout_d;
    end
  end

endmodule
